// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-ASCII-decimal converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int unsigned DEF_IN_W   = 14;
  localparam int unsigned DEF_DIGITS = 4;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble of 5 or more.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  end

endmodule

// File: rtl/bcd_sv_ff.sv
// Iterative double-dabble binary to ASCII decimal converter with level start/done handshake.
// Define BCD_LEADING_BLANK_EN to print leading zeros (except the ones digit) as spaces.
module bcd_sv_ff
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W    = DEF_IN_W,
  parameter int unsigned DIGITS  = DEF_DIGITS,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       bin_in,
  input  logic                  cross_ready,
  output logic [8*DIGITS-1:0]   ascii_out,
  output logic                  bcd_ready
);

  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam logic [IN_W-1:0]  MAX_BIN  = IN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_W);

  state_e               state_q, state_d;
  logic [IN_W-1:0]      bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [8*DIGITS-1:0]  ascii_q, ascii_d, ascii_fmt;
  logic                 ready_q, ready_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble   (bcd_q[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  // Render the finished BCD digits as ASCII, most significant digit first.
  always_comb begin
    logic [3:0] dig;
`ifdef BCD_LEADING_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    dig       = '0;
    ascii_fmt = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = bcd_q[4*(DIGITS-1-i) +: 4];
      ascii_fmt[8*(DIGITS-1-i) +: 8] = ASCII_ZERO + {4'h0, dig};
`ifdef BCD_LEADING_BLANK_EN
      if (lead && (dig == 4'd0) && (i != DIGITS - 1)) begin
        ascii_fmt[8*(DIGITS-1-i) +: 8] = ASCII_SPACE;
      end else begin
        lead = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ascii_d = ascii_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        if (cross_ready) begin
          bin_d   = (bin_in > MAX_BIN) ? MAX_BIN : bin_in;
          bcd_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!cross_ready) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          ascii_d = ascii_fmt;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
          cnt_d          = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (!cross_ready) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ascii_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ascii_q <= ascii_d;
      ready_q <= ready_d;
    end
  end

  assign ascii_out = ascii_q;
  assign bcd_ready = ready_q;

endmodule

// File: tb/tb_bcd_sv_ff.sv
// Self-checking bench for bcd_sv_ff: arithmetic reference model, per-cycle compare, literal pins.
module tb_bcd_sv_ff;

`ifdef BCD_LEADING_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cross_ready = 1'b0;
  logic [13:0] bin_in = '0;
  logic [31:0] ascii_out;
  logic        bcd_ready;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_sv_ff dut (
    .clk         (clk),
    .rst         (rst),
    .bin_in      (bin_in),
    .cross_ready (cross_ready),
    .ascii_out   (ascii_out),
    .bcd_ready   (bcd_ready)
  );

  // Decimal rendering straight from the arithmetic value.
  function automatic logic [31:0] fmt(input int v);
    logic [31:0] r;
    bit lead;
    int p;
    int d;
    r = '0;
    lead = 1'b1;
    p = 1000;
    for (int k = 3; k >= 0; k--) begin
      d = (v / p) % 10;
      p = p / 10;
      if (BLANK && lead && d == 0 && k != 0) begin
        r[8*k +: 8] = 8'h20;
      end else begin
        r[8*k +: 8] = 8'(8'h30 + d);
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 converting (counts edges since start), 2 done.
  int          m_phase = 0;
  int          m_cnt   = 0;
  int          m_val   = 0;
  logic [31:0] m_ascii = '0;
  logic        m_ready = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_ascii = '0;
      m_ready = 1'b0;
    end else begin
      case (m_phase)
        0: if (cross_ready) begin
          m_val   = (int'(bin_in) > 9999) ? 9999 : int'(bin_in);
          m_cnt   = 0;
          m_phase = 1;
        end
        1: if (!cross_ready) begin
          m_phase = 0;
        end else begin
          m_cnt++;
          if (m_cnt == 15) begin
            m_ascii = fmt(m_val);
            m_ready = 1'b1;
            m_phase = 2;
          end
        end
        default: if (!cross_ready) begin
          m_ready = 1'b0;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ascii", ascii_out, m_ascii);
      check("cyc_ready", {31'b0, bcd_ready}, {31'b0, m_ready});
    end
  end

  task automatic start(input int v);
    @(negedge clk);
    bin_in      = 14'(v);
    cross_ready = 1'b1;
  endtask

  task automatic drop();
    @(negedge clk);
    cross_ready = 1'b0;
  endtask

  // Count edges after the sampling edge until bcd_ready rises, bounded.
  task automatic wait_done(input string name);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    @(posedge clk);
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      seen = bcd_ready;
    end
    check({name, "_latency"}, 32'(lat), 32'd15);
  endtask

  task automatic conv(input string name, input int v, input logic [31:0] exp);
    start(v);
    wait_done(name);
    check(name, ascii_out, exp);
    drop();
    @(posedge clk);
    #1;
    check({name, "_drop_ready"}, {31'b0, bcd_ready}, 32'd0);
    check({name, "_drop_held"}, ascii_out, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ascii", ascii_out, 32'h0);
    check("reset_ready", {31'b0, bcd_ready}, 32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    conv("v25",    25,    BLANK ? 32'h20203235 : 32'h30303235);
    conv("v255",   255,   BLANK ? 32'h20323535 : 32'h30323535);
    conv("v0",     0,     BLANK ? 32'h20202030 : 32'h30303030);
    conv("v7",     7,     BLANK ? 32'h20202037 : 32'h30303037);
    conv("v9999",  9999,  32'h39393939);
    conv("v16383", 16383, 32'h39393939);

    // Long hold after done: no retrigger even though bin_in wanders.
    start(500);
    wait_done("hold");
    repeat (40) begin
      @(negedge clk);
      bin_in = 14'($urandom);
    end
    #1;
    check("hold_ready", {31'b0, bcd_ready}, 32'd1);
    check("hold_ascii", ascii_out, BLANK ? 32'h20353030 : 32'h30353030);
    drop();
    conv("v1234", 1234, 32'h31323334);

    // Abort five clocks into the shift phase.
    start(4321);
    @(posedge clk);
    repeat (5) @(posedge clk);
    drop();
    repeat (20) @(posedge clk);
    #1;
    check("abort_ready", {31'b0, bcd_ready}, 32'd0);
    check("abort_ascii", ascii_out, 32'h31323334);

    // Asynchronous reset in the middle of a conversion.
    start(777);
    repeat (6) @(posedge clk);
    #3;
    rst         = 1'b0;
    cross_ready = 1'b0;
    #1;
    check("rst_mid_ascii", ascii_out, 32'h0);
    check("rst_mid_ready", {31'b0, bcd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic: mixed hold lengths, aborts, and bin_in churn after latch.
    for (int i = 0; i < 150; i++) begin
      int v;
      int n;
      v = ($urandom_range(0, 3) == 0) ? int'(9990 + $urandom_range(0, 20))
                                      : int'($urandom_range(0, 16383));
      start(v);
      n = int'($urandom_range(1, 24));
      repeat (n) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) bin_in = 14'($urandom);
      end
      drop();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
